// File: rtl/video_clock_enable_manager.sv
// Lock-sequenced clock-enable generator: CH_COUNT pulse streams from MasterCLK,
// each with a runtime divisor that only takes effect on a period boundary.

module video_clock_enable_channel #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             active_nxt,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_data,
  output logic             ce
);
  logic [DIV_W-1:0] pend, pend_nxt, div, cnt;
  logic             wrap;

  always_comb begin
    pend_nxt = pend;
    if (wr_en) pend_nxt = (wr_data == '0) ? DIV_W'(1) : wr_data;
  end

  // A divisor of 0 or 1 wraps every cycle, so the enable stays high.
  assign wrap = (div <= DIV_W'(1)) || (cnt == div - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= DIV_W'(DEFAULT_DIV);
      div  <= DIV_W'(DEFAULT_DIV);
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      // While idle the active divisor tracks pending, so it is already loaded
      // with the latest value on the first active cycle.
      if (!active || wrap) div <= pend_nxt;
      if (!active_nxt || !active || wrap) cnt <= '0;
      else                                cnt <= cnt + DIV_W'(1);
    end
  end

  assign ce = active && (cnt == '0);
endmodule

module video_clock_enable_manager #(
  parameter int CH_COUNT    = 3,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8,
  parameter int LOCK_DELAY  = 8,
  parameter int STAGGER_GAP = 4,
  parameter int SEL_W       = 2
) (
  input  logic                MasterCLK,
  input  logic                Reset,
  input  logic                Locked,
  input  logic [CH_COUNT-1:0] ChEnable,
  input  logic                DivWrEn,
  input  logic [SEL_W-1:0]    DivWrSel,
  input  logic [DIV_W-1:0]    DivWrData,
  output logic [CH_COUNT-1:0] ChCE,
  output logic [CH_COUNT-1:0] ChReady,
  output logic                AllReady,
  output logic                LockLost
);
  localparam int SW = (LOCK_DELAY  > 1) ? $clog2(LOCK_DELAY)  : 1;
  localparam int GW = (STAGGER_GAP > 1) ? $clog2(STAGGER_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, STAGGER, RUN} state_t;

  state_t              state, state_nxt;
  logic [SW-1:0]       settle_cnt, settle_nxt;
  logic [GW-1:0]       gap_cnt, gap_nxt;
  logic [SEL_W-1:0]    idx, idx_nxt;
  logic [CH_COUNT-1:0] ready, ready_nxt;
  logic [CH_COUNT-1:0] en_q, active, active_nxt, wr_hit;
  logic                lost, lost_nxt;

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    gap_nxt    = gap_cnt;
    idx_nxt    = idx;
    ready_nxt  = ready;
    lost_nxt   = lost;
    case (state)
      IDLE: begin
        if (Locked) begin
          state_nxt  = SETTLE;
          settle_nxt = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SW'(LOCK_DELAY - 1)) begin
          state_nxt    = STAGGER;
          idx_nxt      = '0;
          gap_nxt      = '0;
          ready_nxt[0] = 1'b1;
        end else begin
          settle_nxt = settle_cnt + SW'(1);
        end
      end
      STAGGER: begin
        if (idx == SEL_W'(CH_COUNT - 1)) begin
          state_nxt = RUN;
        end else if (gap_cnt == GW'(STAGGER_GAP - 1)) begin
          gap_nxt = '0;
          idx_nxt = idx + SEL_W'(1);
          for (int c = 0; c < CH_COUNT; c++)
            if (c == int'(idx) + 1) ready_nxt[c] = 1'b1;
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      RUN:     ;
      default: state_nxt = IDLE;
    endcase
    // Losing lock anywhere past IDLE aborts sequencing; pending divisors survive.
    if (state != IDLE && !Locked) begin
      state_nxt  = IDLE;
      settle_nxt = '0;
      gap_nxt    = '0;
      idx_nxt    = '0;
      ready_nxt  = '0;
      lost_nxt   = 1'b1;
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      idx        <= '0;
      ready      <= '0;
      lost       <= 1'b0;
      en_q       <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      gap_cnt    <= gap_nxt;
      idx        <= idx_nxt;
      ready      <= ready_nxt;
      lost       <= lost_nxt;
      en_q       <= ChEnable;
    end
  end

  // Enables are registered so ChCE depends only on flops.
  assign active     = ready & en_q;
  assign active_nxt = ready_nxt & ChEnable;

  for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
    assign wr_hit[c] = DivWrEn && (DivWrSel == SEL_W'(c));
    video_clock_enable_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (MasterCLK),
      .rst        (Reset),
      .active     (active[c]),
      .active_nxt (active_nxt[c]),
      .wr_en      (wr_hit[c]),
      .wr_data    (DivWrData),
      .ce         (ChCE[c])
    );
  end

  assign ChReady  = ready;
  assign AllReady = (state == RUN);
  assign LockLost = lost;
endmodule

// File: tb/tb_video_clock_enable_manager.sv
// Directed + randomized bench for video_clock_enable_manager against a
// timeline model (ready times from lock count, pulses from next-due cycle).

module tb_video_clock_enable_manager;
  localparam int CH = 3, DW = 8, DEF = 8, LD = 8, GAP = 4, SW = 2;

  logic          MasterCLK = 1'b0;
  logic          Reset = 1'b1, Locked = 1'b0, DivWrEn = 1'b0;
  logic [CH-1:0] ChEnable = '1;
  logic [SW-1:0] DivWrSel = '0;
  logic [DW-1:0] DivWrData = '0;
  logic [CH-1:0] ChCE, ChReady;
  logic          AllReady, LockLost;

  video_clock_enable_manager #(
    .CH_COUNT(CH), .DIV_W(DW), .DEFAULT_DIV(DEF),
    .LOCK_DELAY(LD), .STAGGER_GAP(GAP), .SEL_W(SW)
  ) dut (
    .MasterCLK(MasterCLK), .Reset(Reset), .Locked(Locked), .ChEnable(ChEnable),
    .DivWrEn(DivWrEn), .DivWrSel(DivWrSel), .DivWrData(DivWrData),
    .ChCE(ChCE), .ChReady(ChReady), .AllReady(AllReady), .LockLost(LockLost)
  );

  always #5 MasterCLK = ~MasterCLK;

  int tests = 0, fails = 0, cyc = 0;

  // Model: m_since counts lock-qualified cycles since leaving IDLE.
  bit            m_armed, m_lost;
  int            m_since;
  int            pend[CH], nxt[CH];
  bit            en_q[CH], prev_act[CH];
  logic [CH-1:0] m_ce, m_rdy;
  logic          m_all;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (Reset) begin
      m_armed = 0; m_since = 0; m_lost = 0;
      for (int i = 0; i < CH; i++) begin
        pend[i] = DEF; en_q[i] = 0; prev_act[i] = 0; nxt[i] = 0;
      end
    end else begin
      if (!m_armed) begin
        if (Locked) begin m_armed = 1; m_since = 0; end
      end else if (!Locked) begin
        m_armed = 0; m_since = 0; m_lost = 1;
      end else begin
        m_since++;
      end
      if (DivWrEn && DivWrSel < CH) pend[DivWrSel] = (DivWrData == 0) ? 1 : int'(DivWrData);
      for (int i = 0; i < CH; i++) en_q[i] = ChEnable[i];
    end
  endtask

  task automatic model_out();
    bit act;
    for (int i = 0; i < CH; i++) begin
      m_rdy[i] = m_armed && (m_since >= LD + i * GAP);
      act      = m_rdy[i] && en_q[i];
      m_ce[i]  = act && (!prev_act[i] || cyc == nxt[i]);
      if (m_ce[i]) nxt[i] = cyc + ((pend[i] < 1) ? 1 : pend[i]);
      prev_act[i] = act;
    end
    m_all = m_armed && (m_since >= LD + (CH - 1) * GAP + 1);
  endtask

  task automatic tick();
    @(posedge MasterCLK);
    cyc++;
    model_edge();
    #1;
    model_out();
    chk("ChCE", 32'(ChCE), 32'(m_ce));
    chk("ChReady", 32'(ChReady), 32'(m_rdy));
    chk("AllReady", 32'(AllReady), 32'(m_all));
    chk("LockLost", 32'(LockLost), 32'(m_lost));
  endtask

  // Raise Locked from IDLE and measure the start-up timeline on the DUT.
  task automatic seq_check(input string pfx);
    int c_lock, r0, r1, r2, ra;
    int p[$];
    r0 = -1; r1 = -1; r2 = -1; ra = -1;
    Locked = 1'b1;
    c_lock = cyc;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (r0 < 0 && ChReady[0]) r0 = cyc;
      if (r1 < 0 && ChReady[1]) r1 = cyc;
      if (r2 < 0 && ChReady[2]) r2 = cyc;
      if (ra < 0 && AllReady)   ra = cyc;
      if (ChCE[0]) p.push_back(cyc);
    end
    chk({pfx, "_rdy0_delay"}, r0 - (c_lock + 1), LD);
    chk({pfx, "_rdy_gap01"}, r1 - r0, GAP);
    chk({pfx, "_rdy_gap12"}, r2 - r1, GAP);
    chk({pfx, "_all_after_rdy2"}, ra - r2, 1);
    chk({pfx, "_ce0_first"}, (p.size() > 0) ? p[0] - r0 : -1, 0);
    chk({pfx, "_ce0_period"}, (p.size() > 1) ? p[1] - p[0] : -1, 8);
  endtask

  initial begin
    int t0, seen;
    int q[$];
    bit found;

    // Reset wins over Locked and writes.
    Locked = 1'b1; DivWrEn = 1'b1; DivWrSel = 2'd0; DivWrData = 8'd2;
    for (int k = 0; k < 3; k++) tick();
    chk("reset_outputs", 32'({ChCE, ChReady, AllReady, LockLost}), 0);
    Reset = 1'b0; Locked = 1'b0; DivWrEn = 1'b0;
    tick(); tick();

    // Default start-up.
    seq_check("start");

    // Short lock, one-cycle drop, relock.
    Reset = 1'b1; tick(); Reset = 1'b0;
    Locked = 1'b1; seen = 0;
    for (int k = 0; k < 5; k++) begin tick(); seen |= int'(ChReady); end
    Locked = 1'b0; tick(); seen |= int'(ChReady);
    chk("no_early_rdy", seen, 0);
    chk("lock_lost_set", 32'(LockLost), 1);
    seq_check("relock");

    // Mid-period divisor write on channel 1.
    found = 0; t0 = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (m_ce[1]) begin found = 1; t0 = cyc; end
    end
    chk("ch1_pulse_found", 32'(found), 1);
    tick(); tick();
    DivWrEn = 1'b1; DivWrSel = 2'd1; DivWrData = 8'd3;
    tick();
    DivWrEn = 1'b0;
    for (int k = 0; k < 16; k++) begin tick(); if (ChCE[1]) q.push_back(cyc); end
    chk("ch1_gap_old", (q.size() > 0) ? q[0] - t0 : -1, 8);
    chk("ch1_gap_new1", (q.size() > 1) ? q[1] - q[0] : -1, 3);
    chk("ch1_gap_new2", (q.size() > 2) ? q[2] - q[1] : -1, 3);

    // Divisors 0 and 1 on channel 2 give a continuous enable.
    DivWrEn = 1'b1; DivWrSel = 2'd2; DivWrData = 8'd0;
    tick();
    DivWrEn = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    for (int k = 0; k < 5; k++) begin tick(); chk("ch2_div0_high", 32'(ChCE[2]), 1); end
    DivWrEn = 1'b1; DivWrData = 8'd1;
    tick();
    DivWrEn = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); chk("ch2_div1_high", 32'(ChCE[2]), 1); end

    // Channel 0 disabled for 5 cycles.
    ChEnable[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); chk("ch0_gap_low", 32'(ChCE[0]), 0); end
    ChEnable[0] = 1'b1;
    tick();
    chk("ch0_reenable_pulse", 32'(ChCE[0]), 1);
    for (int k = 0; k < 20; k++) tick();

    // Randomized traffic including lock drops and occasional reset.
    for (int k = 0; k < 400; k++) begin
      Reset     = ($urandom_range(0, 199) == 0);
      Locked    = ($urandom_range(0, 59) != 0);
      ChEnable  = CH'($urandom);
      DivWrEn   = ($urandom_range(0, 3) == 0);
      DivWrSel  = SW'($urandom);
      DivWrData = ($urandom_range(0, 15) == 0) ? DW'($urandom) : DW'($urandom_range(0, 10));
      tick();
    end

    // Lock loss in RUN with an out-of-range write, then re-sequence.
    Reset = 1'b1; DivWrEn = 1'b0; ChEnable = '1; Locked = 1'b0;
    tick();
    Reset = 1'b0;
    Locked = 1'b1;
    for (int k = 0; k < 25; k++) tick();
    chk("run_before_loss", 32'(AllReady), 1);
    Locked = 1'b0; DivWrEn = 1'b1; DivWrSel = 2'd3; DivWrData = 8'd2;
    tick();
    DivWrEn = 1'b0;
    chk("loss_clear", 32'({ChCE, ChReady, AllReady}), 0);
    chk("loss_sticky", 32'(LockLost), 1);
    seq_check("after_loss");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/video_clock_enable_manager.md
Name: video_clock_enable_manager

Overview:
- Parametrised successor to the video clock manager: produces CH_COUNT clock-enable pulse streams from MasterCLK instead of extra gated clock trees.
- Startup is lock-sequenced: settle delay after PLL lock, then channels start one at a time.
- Each channel has a runtime-programmable divisor, changed glitch-free.
- Sits after the MMCM; feeds SD, TFT and future video peripherals running on MasterCLK.

Parameters:
- CH_COUNT, 3, number of enable channels (1..16)
- DIV_W, 8, divisor register width
- DEFAULT_DIV, 8, divisor loaded into every channel at reset
- LOCK_DELAY, 8, consecutive Locked-high cycles required before sequencing (>=1)
- STAGGER_GAP, 4, cycles between successive channel starts (>=1)
- SEL_W, 2, width of DivWrSel; must satisfy 2^SEL_W >= CH_COUNT

Ports:
- MasterCLK  in  1  sole clock
- Reset  in  1  synchronous, active-high
- Locked  in  1  PLL lock, already synchronised to MasterCLK
- ChEnable  in  CH_COUNT  per-channel run enable
- DivWrEn  in  1  divisor write strobe
- DivWrSel  in  SEL_W  target channel; values >= CH_COUNT are ignored
- DivWrData  in  DIV_W  new divisor; 0 is treated as 1
- ChCE  out  CH_COUNT  one-cycle enable pulses
- ChReady  out  CH_COUNT  channel started by the sequencer
- AllReady  out  1  sequencer in RUN
- LockLost  out  1  sticky; set when Locked falls while in SETTLE, STAGGER or RUN

Behaviour:
- Reset (synchronous, while Reset=1):
  - ChCE=0, ChReady=0, AllReady=0, LockLost=0, state=IDLE.
  - Pending and active divisors = DEFAULT_DIV.
  - All counters = 0.
- FSM states:
  - IDLE: wait for Locked=1; go to SETTLE with settle counter = 0.
  - SETTLE: count consecutive Locked=1 cycles. When the count reaches LOCK_DELAY, go to STAGGER with index = 0.
  - STAGGER: set ChReady[index]; advance index every STAGGER_GAP cycles. Channel 0 becomes ready on the first STAGGER cycle. After ChReady[CH_COUNT-1] is set, go to RUN on the next cycle.
  - RUN: AllReady=1.
- Lock loss: Locked=0 in SETTLE, STAGGER or RUN gives, on the next edge:
  - state=IDLE; all ChReady, ChCE, AllReady and counters cleared; LockLost=1.
  - Pending divisors are kept.
  - LockLost clears only on Reset.
- Channel active = ChReady[i] & ChEnable[i].
- Channel inactive: counter held at 0, ChCE[i]=0.
- On each activation edge (inactive to active):
  - Active divisor loads from pending.
  - ChCE[i]=1 in the first active cycle.
  - Pulses repeat every d cycles, where d = active divisor (d=0 or 1 means ChCE stays high continuously).
- Counter behaviour:
  - Counts 0..d-1; ChCE asserted combinationally from registered state when count==0.
  - Output is registered-equivalent: no combinational path from ports to ChCE.
- Divisor write: DivWrEn=1 writes the pending register of channel DivWrSel in that cycle.
  - Active divisor takes the pending value only at the wrap cycle (count==d-1) or at activation.
  - The pulse period therefore never truncates mid-period.
  - A write in the same cycle as the wrap is applied at that wrap.
- Width: counter is DIV_W bits; d = 2^DIV_W-1 maximum; no overflow.
- Simultaneous Reset with any other input: Reset wins.
- ChEnable toggling during STAGGER only affects channels whose ChReady is already set.

Test Plan:
- Reset, then Locked=1, all ChEnable=1 (defaults) -> ChReady[0] rises 8 cycles after Locked, ChReady[1] 4 cycles later, ChReady[2] 4 cycles after that; AllReady 1 cycle after ChReady[2]; ChCE[0] period 8.
- Locked held high for 5 cycles, low for 1, then high -> ChReady never rises and LockLost=1; settle restarts and ChReady[0] rises 8 cycles after Locked re-rises.
- In RUN, write DivWrSel=1, DivWrData=3 mid-period (count 2 of 8) -> remaining pulse gap is 8 cycles, then period 3 thereafter.
- DivWrData=0 and DivWrData=1 on channel 2 -> ChCE[2] high continuously after the next wrap.
- ChEnable[0] dropped for 5 cycles in RUN -> ChCE[0]=0 during the gap; pulse in the first re-enabled cycle, then every 8 cycles.
- Locked falls in RUN, then DivWrSel=3 write (CH_COUNT=3) -> all outputs clear next cycle, write ignored, re-sequencing identical to the first scenario.
